// File: rtl/ss_pkg.sv
// Shared types for the ss streaming bus: default beat layout and slice occupancy.
package ss_pkg;

  localparam int SS_NUM_BYTES = 8;
  localparam int SS_USER_BITS = 2;

  typedef struct packed {
    logic [8*SS_NUM_BYTES-1:0] data;
    logic [SS_NUM_BYTES-1:0]   keep;
    logic                      last;
    logic [SS_USER_BITS-1:0]   user;
  } ss_beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ss_occ_e;

  // Flattened beat width, same field order as ss_beat_t.
  function automatic int ss_beat_bits(input int nb, input int ub);
    return 9*nb + 1 + ub;
  endfunction

endpackage

// File: rtl/ss_if.sv
// ss stream link: valid/ready handshake carrying {data, keep, last, user}.
interface ss_if #(
  parameter int NUM_BYTES = 8,
  parameter int USER_BITS = 2
);
  logic                   valid;
  logic                   ready;
  logic [8*NUM_BYTES-1:0] data;
  logic [NUM_BYTES-1:0]   keep;
  logic                   last;
  logic [USER_BITS-1:0]   user;

  modport master (output valid, data, keep, last, user, input ready);
  modport slave  (input valid, data, keep, last, user, output ready);
endinterface

// File: rtl/ss_beat_reg.sv
// One beat-wide register with load enable and async active-low clear.
module ss_beat_reg #(
  parameter int W = 75
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ss_register_slice.sv
// Register slice for the ss bus, one cycle of latency, full throughput.
// Define SS_REG_SLICE_SKID_EN for the two-entry skid build with registered in_ready.
module ss_register_slice
  import ss_pkg::*;
#(
  parameter int NUM_BYTES = 8,
  parameter int USER_BITS = 2
) (
  input  logic   clk,
  input  logic   rst,
  ss_if.slave    in,
  ss_if.master   out
);

  localparam int BW = ss_beat_bits(NUM_BYTES, USER_BITS);

  logic [BW-1:0] w_in_beat;
  logic [BW-1:0] w_main_d;
  logic [BW-1:0] w_main_q;
  logic          w_ld_main;
  logic          w_acc;
  logic          w_drn;
  logic          r_out_valid;

  assign w_in_beat = {in.data, in.keep, in.last, in.user};
  assign w_acc     = in.valid & in.ready;
  assign w_drn     = r_out_valid & out.ready;

  assign {out.data, out.keep, out.last, out.user} = w_main_q;
  assign out.valid = r_out_valid;

  ss_beat_reg #(.W(BW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_ld (w_ld_main),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

`ifdef SS_REG_SLICE_SKID_EN

  ss_occ_e       r_occ;
  ss_occ_e       w_occ_nxt;
  logic          r_in_rdy;
  logic          w_ld_skid;
  logic          w_sel_skid;
  logic [BW-1:0] w_skid_q;

  ss_beat_reg #(.W(BW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_ld (w_ld_skid),
    .i_d  (w_in_beat),
    .o_q  (w_skid_q)
  );

  always_comb begin
    w_occ_nxt  = r_occ;
    w_ld_main  = 1'b0;
    w_ld_skid  = 1'b0;
    w_sel_skid = 1'b0;
    case (r_occ)
      EMPTY: if (w_acc) begin
        w_occ_nxt = ONE;
        w_ld_main = 1'b1;
      end
      ONE: begin
        case ({w_acc, w_drn})
          2'b10: begin w_occ_nxt = TWO;   w_ld_skid = 1'b1; end
          2'b01: begin w_occ_nxt = EMPTY;                   end
          2'b11: begin                    w_ld_main = 1'b1; end
          default: ;
        endcase
      end
      // in_ready is low here, so only a drain can happen.
      TWO: if (w_drn) begin
        w_occ_nxt  = ONE;
        w_ld_main  = 1'b1;
        w_sel_skid = 1'b1;
      end
      default: w_occ_nxt = EMPTY;
    endcase
  end

  assign w_main_d = w_sel_skid ? w_skid_q : w_in_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ       <= EMPTY;
      r_in_rdy    <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_in_rdy    <= (w_occ_nxt != TWO);
      r_out_valid <= (w_occ_nxt != EMPTY);
    end
  end

  assign in.ready = r_in_rdy;

`else

  // Single stage: take a new beat whenever the held one leaves this cycle.
  assign in.ready  = ~r_out_valid | out.ready;
  assign w_ld_main = w_acc;
  assign w_main_d  = w_in_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_out_valid <= 1'b0;
    else      r_out_valid <= w_acc | (r_out_valid & ~out.ready);
  end

`endif

endmodule

// File: tb/tb_ss_register_slice.sv
// Directed bench for ss_register_slice; expectations adapt to SS_REG_SLICE_SKID_EN.
module tb_ss_register_slice;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ss_if #(.NUM_BYTES(8), .USER_BITS(2)) u_in ();
  ss_if #(.NUM_BYTES(8), .USER_BITS(2)) u_out ();

  ss_register_slice #(.NUM_BYTES(8), .USER_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .in  (u_in),
    .out (u_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic [1:0] u);
    u_in.valid = v;
    u_in.data  = d;
    u_in.keep  = k;
    u_in.last  = l;
    u_in.user  = u;
  endtask

  function automatic logic [74:0] out_beat();
    return {u_out.data, u_out.keep, u_out.last, u_out.user};
  endfunction

  // Scoreboard: handshakes observed mid-cycle complete on the following edge.
  logic [74:0] sb[$];
  bit          mon_en  = 1'b0;
  bit          acc_seen = 1'b0;

  always @(negedge clk) begin
    if (mon_en && rst) begin
      acc_seen = u_in.valid && u_in.ready;
      if (acc_seen) sb.push_back({u_in.data, u_in.keep, u_in.last, u_in.user});
      if (u_out.valid && u_out.ready) begin
        if (sb.size() == 0) chk("sb_occ", sb.size(), 1);
        else                chk("sb_beat", out_beat(), sb.pop_front());
      end
    end
  end

  initial begin
    // Reset held with traffic offered.
    rst = 1'b0;
    u_out.ready = 1'b1;
    drive(1'b1, 64'h55, 8'hFF, 1'b1, 2'd3);
    repeat (3) step();
    chk("rst_vld",  u_out.valid, 0);
    chk("rst_beat", out_beat(), 0);
    chk("rst_rdy",  u_in.ready, 1);
    rst = 1'b1;
    u_in.valid = 1'b0;
    step();
    chk("rel_vld", u_out.valid, 0);
    u_out.ready = 1'b0;
    step();
    u_out.ready = 1'b1;
    step();
    chk("tog_vld", u_out.valid, 0);

    // Streaming at full rate.
    for (int i = 1; i <= 100; i++) begin
      logic [63:0] d;
      d = 64'(i);
      drive(1'b1, d, 8'hFF, (i % 8) == 0, d[1:0]);
      chk("strm_rdy", u_in.ready, 1);
      step();
      chk("strm_vld",  u_out.valid, 1);
      chk("strm_data", u_out.data, d);
      chk("strm_last", u_out.last, (i % 8) == 0);
      chk("strm_user", u_out.user, d[1:0]);
    end
    u_in.valid = 1'b0;
    step();
    chk("strm_end", u_out.valid, 0);

    // Backpressure: A held, B offered.
    u_out.ready = 1'b0;
    drive(1'b1, 64'hAA, 8'hFF, 1'b0, 2'd2);
    step();
    chk("bp_a_vld",  u_out.valid, 1);
    chk("bp_a_data", u_out.data, 64'hAA);
    chk("bp_a_user", u_out.user, 2);
    drive(1'b1, 64'hBB, 8'hF0, 1'b1, 2'd1);
    #1;
`ifdef SS_REG_SLICE_SKID_EN
    chk("bp_rdy_b", u_in.ready, 1);
`else
    chk("bp_rdy_b", u_in.ready, 0);
`endif
    step();
`ifdef SS_REG_SLICE_SKID_EN
    u_in.valid = 1'b0;
`endif
    chk("bp_rdy_full", u_in.ready, 0);
    chk("bp_hold0", out_beat(), {64'hAA, 8'hFF, 1'b0, 2'd2});
    step();
    chk("bp_hold1", out_beat(), {64'hAA, 8'hFF, 1'b0, 2'd2});
    chk("bp_hold_vld", u_out.valid, 1);
    u_out.ready = 1'b1;
    step();
    chk("bp_b_vld",  u_out.valid, 1);
    chk("bp_b_beat", out_beat(), {64'hBB, 8'hF0, 1'b1, 2'd1});
    u_in.valid = 1'b0;
    step();
    chk("bp_empty", u_out.valid, 0);

    // Random traffic against the scoreboard.
    drive(1'b0, 64'h0, 8'h0, 1'b0, 2'd0);
    acc_seen = 1'b0;
    mon_en   = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (!u_in.valid || acc_seen)
        drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
              1'($urandom), 2'($urandom));
      u_out.ready = 1'($urandom_range(0, 3) != 0);
      step();
    end
    u_in.valid  = 1'b0;
    u_out.ready = 1'b1;
    repeat (4) step();
    chk("sb_drain", sb.size(), 0);
    chk("sb_idle",  u_out.valid, 0);
    mon_en = 1'b0;

    // Async reset with beats held and no clock edge in between.
    u_out.ready = 1'b0;
    drive(1'b1, 64'hC0C0, 8'h0F, 1'b0, 2'd1);
    step();
    drive(1'b1, 64'hD0D0, 8'hF0, 1'b1, 2'd2);
    step();
    u_in.valid = 1'b0;
    chk("ar_vld_pre", u_out.valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_vld",  u_out.valid, 0);
    chk("ar_beat", out_beat(), 0);
    chk("ar_rdy",  u_in.ready, 1);
    step();
    rst = 1'b1;
    u_out.ready = 1'b1;
    step();
    chk("ar_post0", u_out.valid, 0);
    step();
    chk("ar_post1", u_out.valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ss_register_slice.md
# ss_register_slice

Pipeline register slice for the streaming (`ss`) bus, AXI-Stream style with valid/ready, data, keep, last and user. It cuts every combinational path between an upstream master and a downstream slave and adds one cycle of latency. Beats are never lost, duplicated or reordered. It is inserted wherever timing closure on a stream link needs a register stage.

## Interface
Parameters:
- `NUM_BYTES`, 8: data width in bytes.
- `USER_BITS`, 2: sideband user width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: slice can accept a beat.
- `in_data` in 8*NUM_BYTES: upstream data.
- `in_keep` in NUM_BYTES: byte qualifiers.
- `in_last` in 1: end of packet.
- `in_user` in USER_BITS: sideband.
- `out_valid` out 1: downstream beat valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 8*NUM_BYTES, `out_keep` out NUM_BYTES, `out_last` out 1, `out_user` out USER_BITS: registered beat.

The `ss` interface instance ports, `in` and `out`, map 1:1 onto these signals. Both sides share `clk`/`rst`.

## Operation
- Transfer occurs on a rising `clk` edge when valid && ready on that side.
- A beat is the tuple {data, keep, last, user}. The whole tuple is captured and presented atomically and passed through unmodified; `keep` and `last` are not interpreted.
- All outputs are driven from flops, except `in_ready` in the non-skid build (see Configuration).
- While `out_valid`=1 and `out_ready`=0, all `out_*` hold stable.
- Input stability is not required when `in_ready`=0. A beat is only captured on an accepting edge.
- Skid build, states by occupancy:
  - EMPTY: nothing held.
  - ONE: main register holds a beat.
  - TWO: main and skid registers both hold beats.
- Skid build transitions:
  - EMPTY, accept → ONE.
  - ONE, accept and no drain → TWO.
  - ONE, drain and no accept → EMPTY.
  - ONE, accept and drain → ONE, with the new beat in main.
  - TWO, drain → ONE, with skid moving into main.
  - TWO never accepts, because `in_ready`=0.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` with `out_valid`=1 after edge N.
- Throughput: 1 beat/cycle sustained when `out_ready` is held at 1.
- Asserting `rst` (=0) immediately and asynchronously sets:
  - `out_valid`=0,
  - `out_data`/`out_keep`/`out_last`/`out_user` = 0,
  - skid register empty, state EMPTY.
- `in_ready` reads 1 while in reset and afterward in both builds. Beats are accepted only on edges where `rst`=1.
- Reset mid-packet discards all held beats. No partial beat is emitted afterward.
- Simultaneous accept and drain in ONE: occupancy is unchanged and the new beat is output on the next cycle.
- `out_ready` toggling while `out_valid`=0 has no effect.

## Configuration
- `SS_REG_SLICE_SKID_EN` defined: two-entry skid buffer as above.
  - `in_ready` is a flop equal to (next state != TWO).
  - No combinational path exists from `out_ready` to `in_ready`.
- `SS_REG_SLICE_SKID_EN` undefined: single register stage.
  - `in_ready` = !`out_valid` || `out_ready`, which is combinational.
  - Still 1 beat/cycle and 1-cycle latency.

## Structure
- Shared package `ss_pkg` holds:
  - a beat struct typedef parameterized by `NUM_BYTES`/`USER_BITS` (data, keep, last, user),
  - the occupancy state enum (EMPTY, ONE, TWO).
- One sub-module, `ss_beat_reg`: one beat-wide register with load enable and async active-low clear, instantiated twice for main and skid.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `in_valid`=1 → `out_valid`=0, all `out_*`=0, no beat emitted after release.
- Streaming: `out_ready`=1, send data 0x1..0x64 with keep 0xFF and `last` on every 8th beat → identical sequence out, 1-cycle latency, 1 beat/cycle.
- Backpressure:
  - Setup: `out_ready`=0 with beat A (data 0xAA, user 2) held, then beat B offered.
  - Skid build: B is accepted, then `in_ready`=0.
  - Non-skid build: `in_ready`=0 immediately.
  - Release: A then B delivered in order; `out_*` stable throughout the stall.
- Random traffic: 100 cycles of random `in_valid`/`out_ready`, with inputs changed only when `in_ready` || !`in_valid` → scoreboard matches, no drops or duplicates.
- Async reset mid-stream: pull `rst` low between edges with two beats held → `out_valid` drops without a clock edge; output is empty after release.
- Both builds: run every scenario with and without `SS_REG_SLICE_SKID_EN`. The skid build shows no `out_ready`→`in_ready` combinational path.
